eth_tx_frame_pad: RTL and testbench

AXI-Stream byte stage between the TX asynchronous FIFO read side and the ethernet_mac transmit input (s_tx_axis_*), in the clk_125 domain.
- Forwards frames unchanged when they already meet the Ethernet minimum length.
- Extends short frames (runts) with 0x00 bytes up to MIN_FRAME_BYTES, so the MAC appends FCS to a legal 60-byte payload.
- Provides a registered output stage and a completed-frame counter.

---
 rtl/eth_tx_frame_pad.sv | 131 +++++++++++++
 tb/tb_eth_tx_frame_pad.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_pad.sv
// Byte-wide AXI-Stream stage in front of the MAC transmit input. Passes frames through
// unchanged and extends runt frames with 0x00 bytes up to MIN_FRAME_BYTES so the MAC
// always sees a legal payload length. The output is a single register stage.
module eth_tx_frame_pad #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                  clk_125,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_trdy,
  output logic [DATA_WIDTH-1:0] m_tx_axis_tdata,
  output logic                  m_tx_axis_tvalid,
  output logic                  m_tx_axis_tlast,
  input  logic                  m_tx_axis_trdy,
  output logic                  pad_active,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam logic [CNT_WIDTH-1:0] MinBytes = CNT_WIDTH'(MIN_FRAME_BYTES);
  localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

  typedef enum logic [1:0] {StIdle, StPass, StPad} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  pad_q, pad_d;
  logic [CNT_WIDTH-1:0]  frame_count_q, frame_count_d;

  logic                  ld;
  logic                  in_hs;
  logic [CNT_WIDTH-1:0]  cnt_inc;

  // Output register may load when empty or when its current byte is being taken.
  always_comb begin
    ld          = !tvalid_q || m_tx_axis_trdy;
    // Gated by reset so the FIFO is never popped while the block is held in reset.
    s_axis_trdy = reset_n && ld && (state_q != StPad);
    in_hs       = s_axis_tvalid && s_axis_trdy;
    // Saturating increment: oversize frames keep flowing with a pinned count.
    cnt_inc     = (byte_cnt_q == CntMax) ? byte_cnt_q : byte_cnt_q + CNT_WIDTH'(1);
  end

  // Next-state logic for the FSM, the byte counter and the output register.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    pad_d      = pad_q;
    if (ld) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      case (state_q)
        StIdle, StPass: begin
          if (in_hs) begin
            tdata_d    = s_axis_tdata;
            tvalid_d   = 1'b1;
            byte_cnt_d = (state_q == StIdle) ? CNT_WIDTH'(1) : cnt_inc;
            if (s_axis_tlast) begin
              if (byte_cnt_d >= MinBytes) begin
                tlast_d = 1'b1;
                state_d = StIdle;
              end else begin
                // Runt: hold tlast back and fill with zeros.
                pad_d   = 1'b1;
                state_d = StPad;
              end
            end else begin
              state_d = StPass;
            end
          end
        end
        StPad: begin
          tdata_d    = '0;
          tvalid_d   = 1'b1;
          byte_cnt_d = cnt_inc;
          if (cnt_inc >= MinBytes) begin
            tlast_d = 1'b1;
            pad_d   = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Completed frames are counted as their last byte leaves the block.
  always_comb begin
    frame_count_d = frame_count_q;
    if (tvalid_q && m_tx_axis_trdy && tlast_q) begin
      frame_count_d = frame_count_q + CNT_WIDTH'(1);
    end
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      byte_cnt_q    <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      pad_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      pad_q         <= pad_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_tx_axis_tdata  = tdata_q;
  assign m_tx_axis_tvalid = tvalid_q;
  assign m_tx_axis_tlast  = tlast_q;
  assign pad_active       = pad_q;
  assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_eth_tx_frame_pad.sv
// Scoreboard bench for eth_tx_frame_pad: each frame issued pushes its padded image into a
// queue; a negedge monitor pops and compares every output handshake.
module tb_eth_tx_frame_pad;

  localparam int MIN = 60;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_trdy;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_trdy = 1'b1;
  logic        pad_active;
  logic [15:0] frame_count;

  eth_tx_frame_pad #(
    .DATA_WIDTH     (8),
    .MIN_FRAME_BYTES(MIN),
    .CNT_WIDTH      (16)
  ) dut (
    .clk_125         (clk),
    .reset_n         (reset_n),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_trdy     (s_trdy),
    .m_tx_axis_tdata (m_tdata),
    .m_tx_axis_tvalid(m_tvalid),
    .m_tx_axis_tlast (m_tlast),
    .m_tx_axis_trdy  (m_trdy),
    .pad_active      (pad_active),
    .frame_count     (frame_count)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_tlast_cyc = 0;
  int   strdy_low = 0;
  int   frames_sent = 0;
  bit   pad_seen = 0;
  bit   rand_trdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready: always 1, or a ~50% coin flip per cycle.
  always @(posedge clk) begin
    #1;
    m_trdy = rand_trdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: output handshakes pop the scoreboard; stalled outputs must hold.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    exp_t       e;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (pad_active) pad_seen = 1;
        if (!s_trdy) strdy_low++;
        if (prev_stall) check("stall_hold", {m_tvalid, m_tdata, m_tlast}, {1'b1, prev_d, prev_l});
        if (m_tvalid && m_trdy) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %02h last=%0b, expected no byte", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", {m_tdata, m_tlast}, {e.d, e.l});
            if (m_tlast) last_tlast_cyc = cyc;
          end
        end
        prev_stall = m_tvalid && !m_trdy;
        prev_d     = m_tdata;
        prev_l     = m_tlast;
      end
    end
  end

  // Reference: frame bytes followed by zeros up to MIN, tlast on the final byte only.
  task automatic push_expected(input logic [7:0] fr[$]);
    exp_t e;
    int   n;
    int   total;
    n     = fr.size();
    total = (n >= MIN) ? n : MIN;
    for (int i = 0; i < total; i++) begin
      e.d = (i < n) ? fr[i] : 8'h00;
      e.l = (i == total - 1);
      exp_q.push_back(e);
    end
    frames_sent++;
  endtask

  // Drive one frame; first_cyc is the cycle index of the first input handshake.
  task automatic send_frame(input logic [7:0] fr[$], input int bubble_pct, output int first_cyc);
    bit hs;
    int guard;
    first_cyc = 0;
    push_expected(fr);
    for (int i = 0; i < fr.size(); i++) begin
      if (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = fr[i];
      s_tlast  = (i == fr.size() - 1);
      hs       = 0;
      guard    = 0;
      while (!hs) begin
        @(negedge clk);
        hs = s_trdy;
        @(posedge clk);
        #1;
        guard++;
        if (!hs && guard > 2000) begin
          tests++;
          fails++;
          $display("FAIL input_timeout: s_axis_trdy stuck 0, expected 1 within 2000 cycles");
          s_tvalid = 1'b0;
          s_tlast  = 1'b0;
          return;
        end
      end
      if (i == 0) first_cyc = cyc;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || m_tvalid) && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 5000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d bytes still expected, expected 0", exp_q.size());
      exp_q.delete();
    end
    check("frame_count", 32'(frame_count), 32'(frames_sent[15:0]));
  endtask

  initial begin
    logic [7:0] fr[$];
    int         f0;
    int         f1;
    int         fc0;

    // Reset values.
    #20;
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_tlast", 32'(m_tlast), 0);
    check("rst_tdata", 32'(m_tdata), 0);
    check("rst_pad", 32'(pad_active), 0);
    check("rst_fc", 32'(frame_count), 0);
    check("rst_strdy", 32'(s_trdy), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 64-byte frame: unchanged, 1-cycle latency, no padding.
    fr.delete();
    for (int i = 1; i <= 64; i++) fr.push_back(8'(i));
    pad_seen = 0;
    send_frame(fr, 0, f0);
    wait_drain();
    check("t1_latency", 32'(last_tlast_cyc - f0), 63);
    check("t1_pad_seen", 32'(pad_seen), 0);

    // 10-byte runt: 50 pad bytes, input stalled exactly 50 cycles.
    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(8'hA0 + 8'(i));
    strdy_low = 0;
    send_frame(fr, 0, f0);
    wait_drain();
    check("t2_strdy_low", 32'(strdy_low), 50);
    check("t2_span", 32'(last_tlast_cyc - f0), 59);

    // 59 then 60 bytes back to back: one pad byte, no idle cycle on the output.
    fr.delete();
    for (int i = 0; i < 59; i++) fr.push_back(8'($urandom));
    send_frame(fr, 0, f0);
    fr.delete();
    for (int i = 0; i < 60; i++) fr.push_back(8'($urandom));
    send_frame(fr, 0, f1);
    wait_drain();
    check("t3_no_gap", 32'(last_tlast_cyc - f0), 119);

    // 20-byte frame under random sink backpressure.
    rand_trdy = 1;
    fr.delete();
    for (int i = 0; i < 20; i++) fr.push_back(8'($urandom));
    send_frame(fr, 0, f0);
    wait_drain();
    rand_trdy = 0;
    @(posedge clk);
    #1;

    // Reset during PAD of a 5-byte frame.
    fr.delete();
    for (int i = 0; i < 5; i++) fr.push_back(8'h11 + 8'(i));
    send_frame(fr, 0, f0);
    repeat (10) @(posedge clk);
    #2;
    check("t5_pad_before", 32'(pad_active), 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_tvalid", 32'(m_tvalid), 0);
    check("t5_rst_tlast", 32'(m_tlast), 0);
    check("t5_rst_pad", 32'(pad_active), 0);
    check("t5_rst_fc", 32'(frame_count), 0);
    exp_q.delete();
    frames_sent = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    fr.delete();
    for (int i = 0; i < 60; i++) fr.push_back(8'($urandom));
    send_frame(fr, 0, f0);
    wait_drain();

    // Five 1-byte frames back to back.
    fc0 = int'(frame_count);
    fr.delete();
    fr.push_back(8'h55);
    for (int k = 0; k < 5; k++) send_frame(fr, 0, f0);
    wait_drain();
    check("t6_fc_delta", 32'(int'(frame_count) - fc0), 5);

    // Randomized frames with input bubbles and sink backpressure.
    rand_trdy = 1;
    for (int k = 0; k < 25; k++) begin
      fr.delete();
      for (int i = 0; i < int'($urandom_range(1, 90)); i++) fr.push_back(8'($urandom));
      send_frame(fr, 25, f0);
    end
    wait_drain();
    rand_trdy = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
